voter_stream: RTL and testbench

Streaming majority voter: consumes an N-bit vote vector as a sequence of W-bit beats over a valid/ready stream, accumulates the population count, and returns the majority decision plus the count over a second valid/ready stream. It is the sequential consumer for the dataset vectors that the combinational `voter` evaluates in one shot. It serves as the exact-reference, area-lean counterpart in the voter ALS flow.

---
 rtl/voter_pkg.sv | 36 +++
 rtl/voter_popcount.sv | 26 ++
 rtl/voter_stream.sv | 163 ++++++++++++++++
 tb/tb_voter_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// ----------------------------------------------------------------------------
// voter_pkg
// Shared definitions for the streaming majority voter.
//   clog2()      : ceiling log2, usable in constant expressions
//   N_BITS_DEF   : default vote vector width (1001)
//   W_DEF        : default beat width (32)
//   NBEATS       : beats per vector for the default widths
//   CNT_W        : population count width for the default widths
//   LAST_BITS    : counted bits in the final beat for the default widths
//   state_t      : voter FSM states {ACCUM, DONE}
// ----------------------------------------------------------------------------
package voter_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int N_BITS_DEF = 1001;
    localparam int W_DEF      = 32;
    localparam int NBEATS     = (N_BITS_DEF + W_DEF - 1) / W_DEF;
    localparam int CNT_W      = clog2(N_BITS_DEF + 1);
    localparam int LAST_BITS  = N_BITS_DEF - (NBEATS - 1) * W_DEF;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/voter_popcount.sv
// ----------------------------------------------------------------------------
// voter_popcount
// Combinational popcount of a W-bit word after masking.
//   i_data  [W-1:0]     : word to count
//   i_mask  [W-1:0]     : bit i is counted only when i_mask[i] is 1
//   o_count [PC_W-1:0]  : number of counted ones, PC_W = clog2(W+1)
// ----------------------------------------------------------------------------
module voter_popcount
    import voter_pkg::*;
#(
    parameter  int W    = W_DEF,
    localparam int PC_W = clog2(W + 1)
) (
    input  logic [W-1:0]    i_data,
    input  logic [W-1:0]    i_mask,
    output logic [PC_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + PC_W'(i_data[i] & i_mask[i]);
        end
    end

endmodule

// File: rtl/voter_stream.sv
// ----------------------------------------------------------------------------
// voter_stream
// Streaming majority voter. An N_BITS vote vector arrives as NBEATS beats of
// W bits (beat k holds vector bits [k*W+W-1:k*W], LSB first). The ones are
// accumulated and the decision (2*count > N_BITS) plus the count are returned.
//
// Handshake: on both streams a transfer happens on a rising clock edge where
// valid and ready are both 1. A source holds valid and payload stable until
// the transfer; in_ready depends only on the FSM state, never on in_valid.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : beat stream handshake
//   in_data [W-1:0]     : beat payload (padding above the vector is ignored)
//   in_last             : final beat marker (used only with error checking)
//   out_valid/out_ready : result stream handshake
//   out_vote            : majority decision
//   out_count [CNT_W-1:0]: number of ones in the vector
//   out_err             : framing error flag
//   dbg_state           : current FSM state, for observation only
//
// Build option: define VOTER_STREAM_ERR_EN to terminate vectors on in_last
// and flag framing errors; otherwise termination is by beat count and
// out_err is 0.
// ----------------------------------------------------------------------------
module voter_stream
    import voter_pkg::*;
#(
    parameter  int N_BITS = N_BITS_DEF,
    parameter  int W      = W_DEF,
    localparam int CNT_W  = clog2(N_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_vote,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output state_t           dbg_state
);

    localparam int L_NBEATS    = (N_BITS + W - 1) / W;
    localparam int L_LAST_BITS = N_BITS - (L_NBEATS - 1) * W;
    localparam int L_PC_W      = clog2(W + 1);
    localparam int L_BEAT_W    = (L_NBEATS > 1) ? clog2(L_NBEATS) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [L_BEAT_W-1:0]  r_beat;
    logic                 r_vote;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;

    logic                 w_is_last_beat;
    logic                 w_term;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_consume;
    logic [W-1:0]         w_mask;
    logic [L_PC_W-1:0]    w_pc;
    logic [CNT_W-1:0]     w_sum;
    logic [CNT_W:0]       w_twice;
    logic                 w_vote;

    assign w_is_last_beat = (r_beat == L_BEAT_W'(L_NBEATS - 1));

`ifdef VOTER_STREAM_ERR_EN
    // Either marker ends the vector; it is well framed only when both agree.
    assign w_term = w_is_last_beat || in_last;
    assign w_err  = w_is_last_beat != in_last;
`else
    logic w_unused_in_last;
    assign w_unused_in_last = in_last;
    assign w_term = w_is_last_beat;
    assign w_err  = 1'b0;
`endif

    // Only the low L_LAST_BITS of the final beat belong to the vector.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < W; i++) begin
            w_mask[i] = !w_is_last_beat || (i < L_LAST_BITS);
        end
    end

    voter_popcount #(.W(W)) u_popcount (
        .i_data  (in_data),
        .i_mask  (w_mask),
        .o_count (w_pc)
    );

    assign w_sum   = r_cnt + CNT_W'(w_pc);
    assign w_twice = {w_sum, 1'b0};
    assign w_vote  = w_twice > (CNT_W + 1)'(N_BITS);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && w_term) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    // Accumulator and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_beat  <= '0;
            r_vote  <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_consume) begin
            r_cnt  <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_cnt  <= w_sum;
            r_beat <= r_beat + 1'b1;
            if (w_term) begin
                r_count <= w_sum;
                r_vote  <= w_vote;
                r_err   <= w_err;
            end
        end
    end

    assign out_vote  = r_vote;
    assign out_count = r_count;
    assign out_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_voter_stream.sv
module tb_voter_stream;

  localparam int N     = 1001;
  localparam int WB    = 32;
  localparam int NB    = 32;
  localparam int CNT_W = 10;
  localparam int RW    = CNT_W + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WB-1:0]    in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_vote;
  logic [CNT_W-1:0] out_count;
  logic             out_err;
  logic             dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int bp_pct   = 0;
  bit hold_ready = 1'b0;
  bit chk_ready_pending = 1'b0;

  // {err, vote, count}
  logic [RW-1:0] exp_q[$];

  voter_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vote  (out_vote),
    .out_count (out_count),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Result of a vector: count the ones that belong to the vector (only the
  // beats that were framed into it), then apply the majority rule.
  function automatic logic [RW-1:0] model(input logic [N-1:0] vec, input int early_k, input bit last_ok);
    int cnt;
    int lim;
    bit err;
    cnt = 0;
    lim = N;
    err = 1'b0;
`ifdef VOTER_STREAM_ERR_EN
    if (early_k >= 0 && early_k < NB - 1) begin
      lim = (early_k + 1) * WB;
      err = 1'b1;
    end else if (!last_ok) begin
      err = 1'b1;
    end
`endif
    for (int i = 0; i < lim; i++) cnt += int'(vec[i]);
    return {err, (2 * cnt > N), CNT_W'(cnt)};
  endfunction

  function automatic logic [N-1:0] ones_vec(input int n);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- result sink ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 99) >= bp_pct);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_ready_pending) begin
        check("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
        chk_ready_pending = 1'b0;
      end
      if (out_valid) begin
        check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result actual=%0h required=none at %0t",
                   {out_err, out_vote, out_count}, $time);
        end else begin
          check("result", 32'({out_err, out_vote, out_count}), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            chk_ready_pending = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic put_beat(input logic [WB-1:0] d, input bit last, output bit ok);
    bit rdy;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    if (!ok) begin
      n_checks++;
      $display("FAIL beat_accept_timeout actual=no_ready required=ready at %0t", $time);
    end
  endtask

  // junk_mode: padding bits of the last beat 0=zeros 1=ones 2=random.
  // early_k: beat carrying an early in_last (-1 none). last_ok: in_last on final beat.
  // n_send: beats to drive (NB for a whole vector).
  task automatic send_vec(input logic [N-1:0] vec, input logic [RW-1:0] exp,
                          input int junk_mode, input int gap_pct,
                          input int early_k, input bit last_ok, input int n_send);
    logic [WB-1:0] d;
    int idx;
    bit ok;
    bit term;
    if (n_send == NB) exp_q.push_back(exp);
    for (int k = 0; k < n_send; k++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int i = 0; i < WB; i++) begin
        idx = k * WB + i;
        if (idx < N) d[i] = vec[idx];
        else if (junk_mode == 0) d[i] = 1'b0;
        else if (junk_mode == 1) d[i] = 1'b1;
        else d[i] = 1'($urandom_range(0, 1));
      end
      term = (k == NB - 1);
`ifdef VOTER_STREAM_ERR_EN
      if (k == early_k) term = 1'b1;
`endif
      put_beat(d, (k == NB - 1) ? last_ok : (k == early_k), ok);
      if (!ok) return;
      if (term && n_send == NB) begin
        @(negedge clk);
        check("out_valid_after_last", {31'd0, out_valid}, 32'd1);
        return;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] v;
    int ek;
    bit lok;
    int wait_cnt;

    do_reset(3);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_vals", 32'({out_err, out_vote, out_count}), 32'd0);
    @(posedge clk);
    #1;

    // pin the model with hand-computed values
    check("model_ones", 32'(model(ones_vec(N), -1, 1'b1)), 32'({1'b0, 1'b1, 10'd1001}));
    check("model_500", 32'(model(ones_vec(500), -1, 1'b1)), 32'({1'b0, 1'b0, 10'd500}));
    check("model_501", 32'(model(ones_vec(501), -1, 1'b1)), 32'({1'b0, 1'b1, 10'd501}));

    // directed vectors, back to back
    bp_pct = 0;
    send_vec(ones_vec(N), {1'b0, 1'b1, 10'd1001}, 0, 0, -1, 1'b1, NB);
    send_vec(ones_vec(500), {1'b0, 1'b0, 10'd500}, 2, 0, -1, 1'b1, NB);
    send_vec(ones_vec(501), {1'b0, 1'b1, 10'd501}, 2, 0, -1, 1'b1, NB);
    send_vec('0, {1'b0, 1'b0, 10'd0}, 1, 0, -1, 1'b1, NB);

    // backpressure for 5 cycles in DONE
    hold_ready = 1'b1;
    send_vec(ones_vec(700), {1'b0, 1'b1, 10'd700}, 2, 0, -1, 1'b1, NB);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    hold_ready = 1'b0;
    send_vec(ones_vec(33), {1'b0, 1'b0, 10'd33}, 2, 0, -1, 1'b1, NB);

    // reset in the middle of a vector
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 200) begin
      @(posedge clk);
      wait_cnt++;
    end
    send_vec(ones_vec(N), '0, 1, 0, -1, 1'b1, 10);
    @(posedge clk);
    do_reset(1);
    send_vec(ones_vec(600), {1'b0, 1'b1, 10'd600}, 2, 0, -1, 1'b1, NB);

`ifdef VOTER_STREAM_ERR_EN
    check("model_early5", 32'(model(ones_vec(N), 5, 1'b1)), 32'({1'b1, 1'b0, 10'd192}));
    send_vec(ones_vec(N), {1'b1, 1'b0, 10'd192}, 1, 0, 5, 1'b1, NB);
    send_vec(ones_vec(300), {1'b0, 1'b0, 10'd300}, 2, 0, -1, 1'b1, NB);
    send_vec(ones_vec(N), {1'b1, 1'b1, 10'd1001}, 2, 0, -1, 1'b0, NB);
`endif

    // randomized vectors with gaps, backpressure and stray in_last
    bp_pct = 40;
    for (int n = 0; n < 30; n++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < dens);
      ek  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 2)) : -1;
      lok = ($urandom_range(0, 5) != 0);
      send_vec(v, model(v, ek, lok), 2, 20, ek, lok, NB);
    end

    bp_pct = 0;
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 500) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout actual=%0d required=0 results outstanding", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
